alu_issue_ctrl: RTL

//  Upstream issue/sequencing stage for the ALU. Accepts one instruction word per handshake and

---
 rtl/alu_defs.sv | 33 +++
 rtl/alu_issue_ctrl_regfile.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the ALU issue stage: opcodes,
// instruction field layout, FSM states, immediate helper.
package alu_defs;

    localparam logic [2:0] OP_PASS2 = 3'd0;
    localparam logic [2:0] OP_PASS1 = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_EQ    = 3'd4;
    localparam logic [2:0] OP_LT    = 3'd5;
    localparam logic [2:0] OP_NEG   = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam int FLD_W      = 3;
    localparam int IMM_W      = 16;
    localparam int OP_MSB     = 31;
    localparam int RD_MSB     = 28;
    localparam int RS1_MSB    = 25;
    localparam int RS2_MSB    = 22;
    localparam int IMMSEL_BIT = 19;
    localparam int IMM_MSB    = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: two async read ports plus a debug port,
// one sync write port, R0 hardwired to zero, async clear.
module regfile_2r1w #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    input  logic [AW-1:0] i_rad,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [31:0]   i_wd,
    output logic [31:0]   o_rd1,
    output logic [31:0]   o_rd2,
    output logic [31:0]   o_rdd
);

    logic [31:0] r_mem [NREG];

    // Storage: cleared on reset, writes to R0 discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
    assign o_rdd = (i_rad == '0) ? '0 : r_mem[i_rad];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: accepts an instruction, reads operands,
// drives the external ALU, captures and writes back its result.
module alu_issue_ctrl #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [2:0]    alu_op,
    output logic [31:0]   alu_in1,
    output logic [31:0]   alu_in2,
    input  logic [31:0]   alu_out,
    output logic          done,
    output logic [31:0]   result,
    output logic          illegal,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    import alu_defs::*;

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_ready;
    logic          w_done;
    logic          w_accept;
    logic          w_we;
    logic [2:0]    w_op;
    logic [2:0]    w_rd;
    logic [2:0]    w_rs1;
    logic [2:0]    w_rs2;
    logic          w_isel;
    logic [15:0]   w_imm;
    logic [31:0]   w_rs1_data;
    logic [31:0]   w_rs2_data;
    logic [31:0]   w_in2;
    logic          w_unused;
    logic [2:0]    r_alu_op;
    logic [31:0]   r_alu_in1;
    logic [31:0]   r_alu_in2;
    logic [AW-1:0] r_rd;
    logic          r_ill;
    logic [31:0]   r_res_q;
    logic [31:0]   r_result;

    assign w_op   = instr[OP_MSB -: FLD_W];
    assign w_rd   = instr[RD_MSB -: FLD_W];
    assign w_rs1  = instr[RS1_MSB -: FLD_W];
    assign w_rs2  = instr[RS2_MSB -: FLD_W];
    assign w_isel = instr[IMMSEL_BIT];
    assign w_imm  = instr[IMM_MSB -: IMM_W];

    assign w_unused = ^instr[18:16];

    regfile_2r1w #(
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (AW'(w_rs1)),
        .i_ra2 (AW'(w_rs2)),
        .i_rad (dbg_addr),
        .i_we  (w_we),
        .i_wa  (r_rd),
        .i_wd  (r_res_q),
        .o_rd1 (w_rs1_data),
        .o_rd2 (w_rs2_data),
        .o_rdd (dbg_data)
    );

    assign w_in2 = w_isel ? sext16(w_imm) : w_rs2_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WB;
            end
            S_WB: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = w_ready && instr_valid;
    assign w_we     = w_done && !r_ill && (r_rd != '0);

    // Operand capture on accept; held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op  <= '0;
            r_alu_in1 <= '0;
            r_alu_in2 <= '0;
            r_rd      <= '0;
            r_ill     <= 1'b0;
        end else if (w_accept) begin
            r_alu_op  <= w_op;
            r_alu_in1 <= w_rs1_data;
            r_alu_in2 <= w_in2;
            r_rd      <= AW'(w_rd);
            r_ill     <= (w_op == OP_RSVD);
        end
    end

    // Result capture in EXEC, retired copy held after WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_q  <= '0;
            r_result <= '0;
        end else begin
            if (r_state == S_EXEC) begin
                r_res_q <= r_ill ? '0 : alu_out;
            end
            if (w_done) begin
                r_result <= r_res_q;
            end
        end
    end

    assign instr_ready = w_ready;
    assign done        = w_done;
    assign illegal     = w_done && r_ill;
    assign result      = w_done ? r_res_q : r_result;
    assign alu_op      = r_alu_op;
    assign alu_in1     = r_alu_in1;
    assign alu_in2     = r_alu_in2;

endmodule
